// File: rtl/ft_host_rx_parser.sv
// ---------------------------------------------------------------------------
// ft_host_rx_parser
//
// Parses host frames arriving through a ping-pong input FIFO. Each block is
// claimed, drained byte by byte, and released. The parse state survives the
// release, so frames may straddle any number of blocks.
//
// Frame: SYNC_BYTE, cmd, len[23:16], len[15:8], len[7:0], addr (4 bytes,
// MSB first), then len payload words of 4 bytes each, MSB first.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   in_fifo_ready             a filled block is available to claim
//   in_fifo_activate          claim of the current block
//   in_fifo_count             byte count of the block being claimed
//   in_fifo_read              consume the head byte this cycle
//   in_fifo_data              head byte
//   start_of_frame            head byte starts a host transfer
//   cmd_en                    one-cycle pulse, cmd/cmd_len/cmd_addr valid
//   cmd, cmd_len, cmd_addr    decoded header fields
//   data_valid, data          payload word, held until data_ready
//   data_ready                sink accepts the payload word
//   frame_error               one-cycle pulse on discarded bytes / aborts
//   busy                      parser is not idle
// ---------------------------------------------------------------------------
module ft_host_rx_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_fifo_ready,
  output logic        in_fifo_activate,
  input  logic [23:0] in_fifo_count,
  output logic        in_fifo_read,
  input  logic [7:0]  in_fifo_data,
  input  logic        start_of_frame,
  output logic        cmd_en,
  output logic [7:0]  cmd,
  output logic [23:0] cmd_len,
  output logic [31:0] cmd_addr,
  output logic        data_valid,
  output logic [31:0] data,
  input  logic        data_ready,
  output logic        frame_error,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATE,
    S_SYNC,
    S_HEADER,
    S_PAYLOAD,
    S_WORD_OUT,
    S_RELEASE
  } state_e;

  state_e      state_q, state_d;
  state_e      saved_q, saved_d;       // parse phase to resume after ACTIVATE
  logic [23:0] block_count_q, block_count_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [55:0] hdr_q, hdr_d;           // first 7 header bytes after SYNC
  logic [23:0] word_q, word_d;         // first 3 bytes of a payload word
  logic [23:0] words_left_q, words_left_d;
  logic        activate_q, activate_d;
  logic        in_run_q, in_run_d;     // inside a run of discarded bytes
  logic        cmd_en_q, cmd_en_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] cmd_len_q, cmd_len_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] data_q, data_d;
  logic        frame_error_q, frame_error_d;

  logic        claim;
  logic        rd;
  logic        as_sync;
  logic        abort;
  state_e      parse_nxt;

  // The claim is combinational so the block is taken in the IDLE cycle itself,
  // keeping activate low for a single cycle between back-to-back blocks.
  // Gating with rst keeps activate low while reset is held.
  assign claim = (state_q == S_IDLE) && in_fifo_ready && rst;

  // NOTE: combinational block uses blocking '=' and assigns every target a
  // default first, so no path can leave a variable unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    block_count_d = block_count_q;
    byte_idx_d    = byte_idx_q;
    hdr_d         = hdr_q;
    word_d        = word_q;
    words_left_d  = words_left_q;
    in_run_d      = in_run_q;
    cmd_en_d      = 1'b0;
    cmd_d         = cmd_q;
    cmd_len_d     = cmd_len_q;
    cmd_addr_d    = cmd_addr_q;
    data_valid_d  = data_valid_q;
    data_d        = data_q;
    frame_error_d = 1'b0;
    rd            = 1'b0;
    as_sync       = 1'b0;
    abort         = 1'b0;
    parse_nxt     = state_q;

    case (state_q)
      S_IDLE: begin
        if (claim) begin
          block_count_d = in_fifo_count;
          state_d       = S_ACTIVATE;
        end
      end

      S_ACTIVATE: begin
        state_d = (block_count_q == 24'd0) ? S_RELEASE : saved_q;
      end

      S_SYNC, S_HEADER, S_PAYLOAD: begin
        rd = activate_q && (block_count_q != 24'd0);
        if (rd) begin
          block_count_d = block_count_q - 24'd1;
          // A start-of-frame byte mid-frame aborts it and is then parsed as
          // if the parser were hunting for SYNC.
          abort   = start_of_frame && (state_q != S_SYNC);
          as_sync = (state_q == S_SYNC) || start_of_frame;
          if (abort) begin
            frame_error_d = 1'b1;
          end

          if (as_sync) begin
            if (start_of_frame && (in_fifo_data == SYNC_BYTE)) begin
              parse_nxt  = S_HEADER;
              byte_idx_d = 3'd0;
              in_run_d   = 1'b0;
            end else begin
              parse_nxt = S_SYNC;
              if (!in_run_q) begin
                frame_error_d = 1'b1;
              end
              in_run_d = 1'b1;
            end
          end else if (state_q == S_HEADER) begin
            if (byte_idx_q == 3'd7) begin
              cmd_d        = hdr_q[55:48];
              cmd_len_d    = hdr_q[47:24];
              cmd_addr_d   = {hdr_q[23:0], in_fifo_data};
              cmd_en_d     = 1'b1;
              words_left_d = hdr_q[47:24];
              byte_idx_d   = 3'd0;
              parse_nxt    = (hdr_q[47:24] == 24'd0) ? S_SYNC : S_PAYLOAD;
            end else begin
              hdr_d      = {hdr_q[47:0], in_fifo_data};
              byte_idx_d = byte_idx_q + 3'd1;
              parse_nxt  = S_HEADER;
            end
          end else begin
            if (byte_idx_q == 3'd3) begin
              data_d       = {word_q, in_fifo_data};
              data_valid_d = 1'b1;
              byte_idx_d   = 3'd0;
              parse_nxt    = S_WORD_OUT;
            end else begin
              word_d     = {word_q[15:0], in_fifo_data};
              byte_idx_d = byte_idx_q + 3'd1;
              parse_nxt  = S_PAYLOAD;
            end
          end

          // A pending word is always presented before the block is released.
          state_d = parse_nxt;
          if ((parse_nxt != S_WORD_OUT) && (block_count_d == 24'd0)) begin
            state_d = S_RELEASE;
            saved_d = parse_nxt;
          end
        end
      end

      S_WORD_OUT: begin
        if (data_ready) begin
          data_valid_d = 1'b0;
          words_left_d = words_left_q - 24'd1;
          parse_nxt    = (words_left_q == 24'd1) ? S_SYNC : S_PAYLOAD;
          state_d      = parse_nxt;
          if (block_count_q == 24'd0) begin
            state_d = S_RELEASE;
            saved_d = parse_nxt;
          end
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    activate_d = (state_d != S_IDLE) && (state_d != S_RELEASE);
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      saved_q       <= S_SYNC;
      block_count_q <= '0;
      byte_idx_q    <= '0;
      hdr_q         <= '0;
      word_q        <= '0;
      words_left_q  <= '0;
      activate_q    <= 1'b0;
      in_run_q      <= 1'b0;
      cmd_en_q      <= 1'b0;
      cmd_q         <= '0;
      cmd_len_q     <= '0;
      cmd_addr_q    <= '0;
      data_valid_q  <= 1'b0;
      data_q        <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      saved_q       <= saved_d;
      block_count_q <= block_count_d;
      byte_idx_q    <= byte_idx_d;
      hdr_q         <= hdr_d;
      word_q        <= word_d;
      words_left_q  <= words_left_d;
      activate_q    <= activate_d;
      in_run_q      <= in_run_d;
      cmd_en_q      <= cmd_en_d;
      cmd_q         <= cmd_d;
      cmd_len_q     <= cmd_len_d;
      cmd_addr_q    <= cmd_addr_d;
      data_valid_q  <= data_valid_d;
      data_q        <= data_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign in_fifo_activate = activate_q || claim;
  assign in_fifo_read     = rd;
  assign cmd_en           = cmd_en_q;
  assign cmd              = cmd_q;
  assign cmd_len          = cmd_len_q;
  assign cmd_addr         = cmd_addr_q;
  assign data_valid       = data_valid_q;
  assign data             = data_q;
  assign frame_error      = frame_error_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_ft_host_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_ft_host_rx_parser
//
// Directed bench for ft_host_rx_parser. A small ping-pong FIFO model serves
// staged blocks; a linear stream parser predicts the headers, payload words
// and frame_error pulses; one per-cycle process drives the FIFO side and
// compares every cmd_en, every word transfer and the handshake rules.
// ---------------------------------------------------------------------------
module tb_ft_host_rx_parser;

  localparam logic [7:0] SYNC = 8'hCD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_fifo_ready = 1'b0;
  logic        in_fifo_activate;
  logic [23:0] in_fifo_count = '0;
  logic        in_fifo_read;
  logic [7:0]  in_fifo_data = '0;
  logic        start_of_frame = 1'b0;
  logic        cmd_en;
  logic [7:0]  cmd;
  logic [23:0] cmd_len;
  logic [31:0] cmd_addr;
  logic        data_valid;
  logic [31:0] data;
  logic        data_ready = 1'b1;
  logic        frame_error;
  logic        busy;

  ft_host_rx_parser #(.SYNC_BYTE(SYNC)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_fifo_ready    (in_fifo_ready),
    .in_fifo_activate (in_fifo_activate),
    .in_fifo_count    (in_fifo_count),
    .in_fifo_read     (in_fifo_read),
    .in_fifo_data     (in_fifo_data),
    .start_of_frame   (start_of_frame),
    .cmd_en           (cmd_en),
    .cmd              (cmd),
    .cmd_len          (cmd_len),
    .cmd_addr         (cmd_addr),
    .data_valid       (data_valid),
    .data             (data),
    .data_ready       (data_ready),
    .frame_error      (frame_error),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Staging area, FIFO model and expectation queues. Bytes are {sof, byte}.
  logic [8:0]  stg_bytes[$];
  logic [23:0] stg_sizes[$];
  int          blk_len = 0;
  logic [8:0]  pend_bytes[$];
  logic [23:0] pend_sizes[$];
  logic [8:0]  cur[$];
  bit          holding = 0;
  logic [8:0]  stream[$];
  logic [63:0] exp_cmd[$];
  logic [31:0] exp_word[$];
  int          exp_err = 0;

  // Observations.
  logic [63:0] obs_cmd[$];
  logic [31:0] obs_word[$];
  int          obs_err = 0;
  int          obs_falls = 0;
  int          low_cnt = 0;
  int          last_gap = 0;

  task automatic put(input logic sof, input logic [7:0] b);
    stg_bytes.push_back({sof, b});
    blk_len++;
  endtask

  task automatic cut();
    stg_sizes.push_back(24'(blk_len));
    blk_len = 0;
  endtask

  task automatic put_hdr(input logic [7:0] c, input logic [23:0] l, input logic [31:0] a);
    put(1'b1, SYNC);
    put(1'b0, c);
    put(1'b0, l[23:16]);
    put(1'b0, l[15:8]);
    put(1'b0, l[7:0]);
    put(1'b0, a[31:24]);
    put(1'b0, a[23:16]);
    put(1'b0, a[15:8]);
    put(1'b0, a[7:0]);
  endtask

  task automatic put_word(input logic [31:0] w);
    put(1'b0, w[31:24]);
    put(1'b0, w[23:16]);
    put(1'b0, w[15:8]);
    put(1'b0, w[7:0]);
  endtask

  // Reads up to cnt bytes from stream at pos into acc. st: 0 ok, 1 a
  // start-of-frame byte was met (pos left on it), 2 the stream ran out.
  task automatic take(input int cnt, inout int pos, inout logic [63:0] acc, output int st);
    st = 0;
    for (int k = 0; k < cnt; k++) begin
      if (st == 0) begin
        if (pos >= stream.size()) st = 2;
        else if (stream[pos][8]) st = 1;
        else begin
          acc = {acc[55:0], stream[pos][7:0]};
          pos++;
        end
      end
    end
  endtask

  // Reference: walk the whole byte stream once, frame by frame.
  task automatic model_parse();
    int          i = 0;
    int          pos;
    int          st;
    int          len;
    bit          in_run = 0;
    logic [63:0] acc;
    while (i < stream.size()) begin
      if (!(stream[i][8] && stream[i][7:0] == SYNC)) begin
        if (!in_run) exp_err++;
        in_run = 1;
        i++;
      end else begin
        in_run = 0;
        pos = i + 1;
        acc = '0;
        take(8, pos, acc, st);
        if (st == 0) begin
          exp_cmd.push_back(acc);
          len = int'(acc[55:32]);
          for (int w = 0; w < len && st == 0; w++) begin
            acc = '0;
            take(4, pos, acc, st);
            if (st == 0) exp_word.push_back(acc[31:0]);
          end
        end
        if (st == 1) begin
          exp_err++;
          in_run = 1;
        end
        i = (st == 2) ? stream.size() : pos;
      end
    end
  endtask

  task automatic go();
    stream = stg_bytes;
    model_parse();
    foreach (stg_bytes[k]) pend_bytes.push_back(stg_bytes[k]);
    foreach (stg_sizes[k]) pend_sizes.push_back(stg_sizes[k]);
    stg_bytes.delete();
    stg_sizes.delete();
  endtask

  task automatic start_test();
    obs_cmd.delete();
    obs_word.delete();
    obs_err   = 0;
    exp_err   = 0;
    obs_falls = 0;
    last_gap  = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int  c = 0;
    bit  done = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      #2;
      c++;
      done = (pend_sizes.size() == 0) && !holding && !busy && !data_valid;
    end
    check({name, "_done_in_budget"}, 64'(done), 64'd1);
  endtask

  task automatic finish_test(input string name);
    check({name, "_cmds_drained"}, 64'(exp_cmd.size()), 64'd0);
    check({name, "_words_drained"}, 64'(exp_word.size()), 64'd0);
    check({name, "_frame_errors"}, 64'(obs_err), 64'(exp_err));
    check({name, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  // Per-cycle driver and compare process. Inputs change on the falling edge,
  // outputs are sampled 1 time unit later; both describe the next rising edge.
  initial begin : monitor
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    bit          prev_act   = 0;
    logic [31:0] prev_data  = '0;
    int          n;
    forever begin
      @(negedge clk);
      in_fifo_ready = !holding && (pend_sizes.size() != 0);
      in_fifo_count = (pend_sizes.size() != 0) ? pend_sizes[0] : 24'd0;
      if (holding && cur.size() != 0) begin
        in_fifo_data   = cur[0][7:0];
        start_of_frame = cur[0][8];
      end else begin
        in_fifo_data   = 8'h00;
        start_of_frame = 1'b0;
      end
      #1;
      if (!rst) begin
        holding = 0;
        cur.delete();
        prev_valid = 0;
        prev_ready = 0;
        prev_act   = 0;
      end else begin
        if (in_fifo_read) begin
          check("read_needs_activate", 64'(in_fifo_activate), 64'd1);
          check("read_within_block", 64'(holding && cur.size() != 0), 64'd1);
          check("no_read_while_word_pending", 64'(data_valid), 64'd0);
        end
        if (prev_valid && !prev_ready) begin
          check("valid_held", 64'(data_valid), 64'd1);
          check("data_held", 64'(data), 64'(prev_data));
        end
        if (cmd_en) begin
          if (exp_cmd.size() == 0) check("cmd_en_unexpected", 64'(cmd_en), 64'd0);
          else check("cmd_fields", {cmd, cmd_len, cmd_addr}, exp_cmd.pop_front());
          obs_cmd.push_back({cmd, cmd_len, cmd_addr});
        end
        if (data_valid && data_ready) begin
          if (exp_word.size() == 0) check("word_unexpected", 64'(data_valid), 64'd0);
          else check("word_data", 64'(data), 64'(exp_word.pop_front()));
          obs_word.push_back(data);
        end
        if (frame_error) obs_err++;
        if (!in_fifo_activate) begin
          if (prev_act) begin
            low_cnt = 1;
            obs_falls++;
          end else begin
            low_cnt++;
          end
        end else if (!prev_act) begin
          last_gap = low_cnt;
        end
        // FIFO bookkeeping for the coming edge.
        if (!holding && in_fifo_activate && in_fifo_ready) begin
          holding = 1;
          n = int'(pend_sizes.pop_front());
          for (int k = 0; k < n; k++) cur.push_back(pend_bytes.pop_front());
        end else if (holding && in_fifo_read) begin
          void'(cur.pop_front());
        end else if (holding && !in_fifo_activate) begin
          holding = 0;
        end
        prev_valid = data_valid;
        prev_ready = data_ready;
        prev_data  = data;
        prev_act   = in_fifo_activate;
      end
    end
  end

  initial begin : tests
    int c;

    // Reset, with a block already offered: nothing may be claimed.
    #1 rst = 1'b0;
    start_test();
    put_hdr(8'h01, 24'd1, 32'h0000_1000);
    put_word(32'hDEAD_BEEF);
    cut();
    go();
    repeat (3) @(negedge clk);
    #2;
    check("reset_activate", 64'(in_fifo_activate), 64'd0);
    check("reset_read", 64'(in_fifo_read), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_cmd_en", 64'(cmd_en), 64'd0);
    check("reset_data_valid", 64'(data_valid), 64'd0);
    check("reset_fields", {cmd, cmd_len, cmd_addr}, 64'd0);
    check("reset_data", 64'(data), 64'd0);
    #1 rst = 1'b1;

    // Single 13-byte block.
    wait_done("single", 200);
    finish_test("single");
    check("single_cmd_count", 64'(obs_cmd.size()), 64'd1);
    if (obs_cmd.size() != 0) check("single_cmd_lit", obs_cmd[0], 64'h01_000001_0000_1000);
    check("single_word_count", 64'(obs_word.size()), 64'd1);
    if (obs_word.size() != 0) check("single_word_lit", 64'(obs_word[0]), 64'hDEAD_BEEF);
    check("single_releases", 64'(obs_falls), 64'd1);

    // Same frame split 6/7 across two blocks.
    start_test();
    put(1'b1, 8'hCD); put(1'b0, 8'h01); put(1'b0, 8'h00);
    put(1'b0, 8'h00); put(1'b0, 8'h01); put(1'b0, 8'h00);
    cut();
    put(1'b0, 8'h00); put(1'b0, 8'h10); put(1'b0, 8'h00);
    put_word(32'hDEAD_BEEF);
    cut();
    go();
    wait_done("split", 200);
    finish_test("split");
    if (obs_cmd.size() != 0) check("split_cmd_lit", obs_cmd[0], 64'h01_000001_0000_1000);
    if (obs_word.size() != 0) check("split_word_lit", 64'(obs_word[0]), 64'hDEAD_BEEF);
    check("split_releases", 64'(obs_falls), 64'd2);
    check("split_activate_gap", 64'(last_gap), 64'd1);

    // Two words, sink stalls for 10 cycles on the first.
    start_test();
    data_ready = 1'b0;
    put_hdr(8'h22, 24'd2, 32'h0000_0040);
    put_word(32'h1122_3344);
    put_word(32'h5566_7788);
    cut();
    go();
    c = 0;
    while (!data_valid && c < 200) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("stall_word_seen", 64'(data_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      #2;
      check("stall_valid", 64'(data_valid), 64'd1);
      check("stall_data", 64'(data), 64'h1122_3344);
      check("stall_no_read", 64'(in_fifo_read), 64'd0);
    end
    @(negedge clk);
    data_ready = 1'b1;
    wait_done("stall", 200);
    finish_test("stall");
    check("stall_word_count", 64'(obs_word.size()), 64'd2);
    if (obs_word.size() == 2) check("stall_word2_lit", 64'(obs_word[1]), 64'h5566_7788);

    // Leading garbage before a valid frame.
    start_test();
    put(1'b0, 8'h00);
    put(1'b0, 8'h55);
    put_hdr(8'h07, 24'd1, 32'h8000_0004);
    put_word(32'h0102_0304);
    cut();
    go();
    wait_done("junk", 200);
    finish_test("junk");
    check("junk_err_lit", 64'(obs_err), 64'd1);
    if (obs_cmd.size() != 0) check("junk_cmd_lit", obs_cmd[0], 64'h07_000001_8000_0004);

    // Start-of-frame on the third header byte, which is itself a SYNC byte.
    start_test();
    put(1'b1, 8'hCD); put(1'b0, 8'h09); put(1'b0, 8'h00);
    put_hdr(8'h03, 24'd0, 32'hAABB_CCDD);
    cut();
    go();
    wait_done("abort_hdr", 200);
    finish_test("abort_hdr");
    check("abort_hdr_err_lit", 64'(obs_err), 64'd1);
    check("abort_hdr_cmd_count", 64'(obs_cmd.size()), 64'd1);
    if (obs_cmd.size() != 0) check("abort_hdr_cmd_lit", obs_cmd[0], 64'h03_000000_AABB_CCDD);

    // Maximum length header, aborted by a new frame on its first payload byte.
    start_test();
    put_hdr(8'h01, 24'hFF_FFFF, 32'h1234_5678);
    put_hdr(8'h05, 24'd0, 32'hCAFE_F00D);
    cut();
    go();
    wait_done("max_len", 200);
    finish_test("max_len");
    check("max_len_cmd_count", 64'(obs_cmd.size()), 64'd2);
    if (obs_cmd.size() != 0) check("max_len_cmd_lit", obs_cmd[0], 64'h01_FFFFFF_1234_5678);

    // Block boundaries on the last header byte and on the last byte of a word,
    // plus a SYNC value without start-of-frame that must be dropped.
    start_test();
    put(1'b0, 8'hCD);
    put_hdr(8'h04, 24'd2, 32'h0000_2000);
    cut();
    put_word(32'h0102_0304);
    cut();
    put_word(32'h0A0B_0C0D);
    cut();
    go();
    wait_done("bounds", 300);
    finish_test("bounds");
    check("bounds_releases", 64'(obs_falls), 64'd3);
    if (obs_word.size() == 2) check("bounds_word2_lit", 64'(obs_word[1]), 64'h0A0B_0C0D);

    // Reset in PAYLOAD, then a frame that has to resynchronise.
    start_test();
    put_hdr(8'h11, 24'd3, 32'h0000_0100);
    put_word(32'h1111_1111);
    put_word(32'h2222_2222);
    put_word(32'h3333_3333);
    cut();
    go();
    c = 0;
    while (obs_cmd.size() == 0 && c < 200) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("rst_mid_cmd_seen", 64'(obs_cmd.size()), 64'd1);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_activate", 64'(in_fifo_activate), 64'd0);
    check("rst_mid_read", 64'(in_fifo_read), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(data_valid), 64'd0);
    check("rst_mid_fields", {cmd, cmd_len, cmd_addr}, 64'd0);
    check("rst_mid_data", 64'(data), 64'd0);
    pend_bytes.delete();
    pend_sizes.delete();
    exp_cmd.delete();
    exp_word.delete();
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    start_test();
    put(1'b0, 8'h22);
    put(1'b0, 8'h33);
    put_hdr(8'h12, 24'd1, 32'h0000_0200);
    put_word(32'h4444_4444);
    cut();
    go();
    wait_done("post_rst", 200);
    finish_test("post_rst");
    check("post_rst_err_lit", 64'(obs_err), 64'd1);
    if (obs_word.size() != 0) check("post_rst_word_lit", 64'(obs_word[0]), 64'h4444_4444);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
